// File: rtl/cve2_xif_offload_tracker.sv
// Tracks instructions offloaded over the XIF interface from issue through commit and result
// to in-order retirement. Allocates sequential IDs and flags protocol violations.
module cve2_xif_offload_tracker #(
    parameter int unsigned X_ID_WIDTH = 4,
    parameter int unsigned DEPTH      = 4,
    localparam int unsigned CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  issue_fire_i,
    input  logic                  issue_accept_i,
    input  logic                  issue_writeback_i,
    output logic [X_ID_WIDTH-1:0] next_id_o,
    output logic                  full_o,
    input  logic                  commit_valid_i,
    input  logic [X_ID_WIDTH-1:0] commit_id_i,
    input  logic                  commit_kill_i,
    input  logic                  result_fire_i,
    input  logic [X_ID_WIDTH-1:0] result_id_i,
    output logic [CNT_W-1:0]      outstanding_o,
    output logic                  empty_o,
    output logic                  wb_pending_o,
    output logic                  proto_err_o
);

    localparam int unsigned IDX_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        SlotIdle,
        SlotWaitCommit,
        SlotWaitResult,
        SlotDone
    } slot_state_e;

    slot_state_e [DEPTH-1:0] state_q, state_d;
    logic [DEPTH-1:0]        wb_q, wb_d;
    logic [X_ID_WIDTH-1:0]   head_q, head_d;
    logic [X_ID_WIDTH-1:0]   tail_q, tail_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic                    err_q, err_d;

    logic [IDX_W-1:0] head_idx, tail_idx, commit_idx, result_idx;
    logic             full, alloc, retire;
    logic             commit_new, commit_ok, result_ok;
    logic             issue_err, commit_err, result_err;

    // ID is live when its distance from the oldest ID is below the occupancy count.
    function automatic logic in_window(input logic [X_ID_WIDTH-1:0] id,
                                       input logic [X_ID_WIDTH-1:0] head,
                                       input logic [CNT_W-1:0]      cnt);
        logic [X_ID_WIDTH-1:0] off;
        off = id - head;
        return 32'(off) < 32'(cnt);
    endfunction

    assign head_idx   = head_q[IDX_W-1:0];
    assign tail_idx   = tail_q[IDX_W-1:0];
    assign commit_idx = commit_id_i[IDX_W-1:0];
    assign result_idx = result_id_i[IDX_W-1:0];

    assign full   = (32'(count_q) == 32'(DEPTH));
    assign alloc  = issue_fire_i & issue_accept_i & ~full;
    assign retire = (count_q != '0) & (state_q[head_idx] == SlotDone);

    // A commit may target the entry allocated in the same cycle; it is not yet in the window.
    assign commit_new = alloc & (commit_id_i == tail_q);
    assign commit_ok  = commit_valid_i &
                        (commit_new |
                         (in_window(commit_id_i, head_q, count_q) &
                          (state_q[commit_idx] == SlotWaitCommit)));
    assign result_ok  = result_fire_i &
                        in_window(result_id_i, head_q, count_q) &
                        (state_q[result_idx] == SlotWaitResult);

    assign issue_err  = issue_fire_i & full;
    assign commit_err = commit_valid_i & ~commit_ok;
    assign result_err = result_fire_i & ~result_ok;

    always_comb begin
        state_d = state_q;
        wb_d    = wb_q;
        for (int s = 0; s < DEPTH; s++) begin
            if (alloc && (IDX_W'(s) == tail_idx)) begin
                state_d[s] = SlotWaitCommit;
                wb_d[s]    = issue_writeback_i;
            end
            if (commit_ok && (IDX_W'(s) == commit_idx)) begin
                state_d[s] = commit_kill_i ? SlotDone : SlotWaitResult;
            end
            if (result_ok && (IDX_W'(s) == result_idx)) begin
                state_d[s] = SlotDone;
            end
            if (retire && (IDX_W'(s) == head_idx)) begin
                state_d[s] = SlotIdle;
                wb_d[s]    = 1'b0;
            end
        end
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        err_d   = err_q | issue_err | commit_err | result_err;
        if (alloc) begin
            tail_d = tail_q + 1'b1;
        end
        if (retire) begin
            head_d = head_q + 1'b1;
        end
        count_d = count_q + CNT_W'(alloc) - CNT_W'(retire);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= {DEPTH{SlotIdle}};
            wb_q    <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wb_q    <= wb_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        wb_pending_o = 1'b0;
        for (int s = 0; s < DEPTH; s++) begin
            if (wb_q[s] && ((state_q[s] == SlotWaitCommit) || (state_q[s] == SlotWaitResult))) begin
                wb_pending_o = 1'b1;
            end
        end
    end

    assign next_id_o     = tail_q;
    assign outstanding_o = count_q;
    assign full_o        = full;
    assign empty_o       = (count_q == '0);
    assign proto_err_o   = err_q;

endmodule
